// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation front end: macroblock
// geometry, the current-frame fetch state encoding and a width helper.
package me_pkg;

  localparam int MB_SIZE       = 16;  // pixels per macroblock side
  localparam int WORDS_PER_ROW = 4;   // 32-bit words per macroblock row
  localparam int WORDS_PER_MB  = 64;  // 16 rows x 4 words

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cur_fifo.sv
// Small synchronous FIFO used as the prefetch buffer in front of CurBuffer.
// Ports:
//   clk, rst   clock, synchronous active-high reset (pointers/count only)
//   push/wdata write one entry at the clock edge
//   pop        remove the head entry at the clock edge (caller guarantees data)
//   count      current occupancy, 0..DEPTH
//   head       head entry, forced to 0 while empty
//   not_empty  occupancy is non-zero
module cur_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head,
  output logic                       not_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only; it needs no reset because count gates it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign count     = count_q;
  assign not_empty = (count_q != '0);
  assign head      = not_empty ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/cur_fetch.sv
// Current-frame fetcher: walks 16x16 macroblocks in raster order, reads each
// block as 16 rows x 4 words from frame memory and streams the words to
// CurBuffer through a prefetch FIFO.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, frame_base begin a frame at word address frame_base (ignored while busy)
//   mem_rd, mem_addr  read request to frame memory
//   mem_rdata         read data, one cycle after mem_rd
//   need_cur          CurBuffer pops the head word when cur_valid is high
//   cur_in, cur_valid FIFO head and non-empty flag
//   block_done        pulse after the last word of a block is popped
//   frame_done        pulse after the last word of the frame is popped
//   busy              frame in progress
//   underflow         sticky: need_cur while the FIFO was empty
module cur_fetch
  import me_pkg::*;
#(
  parameter int FRAME_W    = 64,
  parameter int FRAME_H    = 64,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] frame_base,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              need_cur,
  output logic [31:0]       cur_in,
  output logic              cur_valid,
  output logic              block_done,
  output logic              frame_done,
  output logic              busy,
  output logic              underflow
);

  localparam int MBX_N      = FRAME_W / MB_SIZE;
  localparam int MBY_N      = FRAME_H / MB_SIZE;
  localparam int NBLK       = MBX_N * MBY_N;
  localparam int LINE_WORDS = FRAME_W / WORDS_PER_ROW;
  localparam int COL_W      = $clog2(WORDS_PER_ROW);
  localparam int ROW_W      = $clog2(MB_SIZE);
  localparam int WORD_W     = $clog2(WORDS_PER_MB);
  localparam int MBX_W      = cnt_w(MBX_N);
  localparam int MBY_W      = cnt_w(MBY_N);
  localparam int BLK_W      = cnt_w(NBLK);
  localparam int FCNT_W     = $clog2(FIFO_DEPTH + 1);

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WORDS_PER_ROW - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(MB_SIZE - 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS_PER_MB - 1);
  localparam logic [MBX_W-1:0]  MBX_LAST  = MBX_W'(MBX_N - 1);
  localparam logic [MBY_W-1:0]  MBY_LAST  = MBY_W'(MBY_N - 1);
  localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(NBLK - 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [MBX_W-1:0]  mbx_q, mbx_d;
  logic [MBY_W-1:0]  mby_q, mby_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic              inflight_q, inflight_d;
  logic              underflow_q, underflow_d;
  logic              block_done_q, block_done_d;
  logic              frame_done_q, frame_done_d;

  logic [FCNT_W-1:0] fifo_count;
  logic [31:0]       fifo_head;
  logic              fifo_nempty;
  logic              start_ok, issue, last_issue, pop;
  logic [ADDR_W-1:0] issue_addr;

  assign start_ok = start && (state_q == IDLE);
  // Credit check uses registered occupancy only; a same-cycle pop is not
  // counted, which costs at most one bubble but keeps the path short.
  assign issue = (state_q == FETCH) &&
                 ((32'(fifo_count) + 32'(inflight_q)) < 32'(FIFO_DEPTH));
  assign last_issue = issue && (col_q == COL_LAST) && (row_q == ROW_LAST) &&
                      (mbx_q == MBX_LAST) && (mby_q == MBY_LAST);
  assign pop = need_cur && fifo_nempty;

  // Address wraps modulo 2^ADDR_W by truncation.
  assign issue_addr = ADDR_W'(32'(base_q)
                    + (32'(mby_q) * 32'(MB_SIZE) + 32'(row_q)) * 32'(LINE_WORDS)
                    + 32'(mbx_q) * 32'(WORDS_PER_ROW) + 32'(col_q));

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    col_d        = col_q;
    row_d        = row_q;
    mbx_d        = mbx_q;
    mby_d        = mby_q;
    word_d       = word_q;
    blk_d        = blk_q;
    inflight_d   = issue;
    underflow_d  = underflow_q;
    block_done_d = 1'b0;
    frame_done_d = 1'b0;

    // Address counters: col innermost, then row, mb_x, mb_y.
    if (issue) begin
      col_d = col_q + COL_W'(1);
      if (col_q == COL_LAST) begin
        row_d = row_q + ROW_W'(1);
        if (row_q == ROW_LAST) begin
          if (mbx_q == MBX_LAST) begin
            mbx_d = '0;
            mby_d = (mby_q == MBY_LAST) ? '0 : mby_q + MBY_W'(1);
          end else begin
            mbx_d = mbx_q + MBX_W'(1);
          end
        end
      end
    end

    // Consume counters drive the done pulses one cycle after the pop.
    if (pop) begin
      word_d = word_q + WORD_W'(1);
      if (word_q == WORD_LAST) begin
        block_done_d = 1'b1;
        blk_d        = (blk_q == BLK_LAST) ? '0 : blk_q + BLK_W'(1);
        frame_done_d = (blk_q == BLK_LAST);
      end
    end

    if (start_ok)                     underflow_d = 1'b0;
    else if (need_cur && !fifo_nempty) underflow_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = FETCH;
          base_d  = frame_base;
          col_d   = '0;
          row_d   = '0;
          mbx_d   = '0;
          mby_d   = '0;
          word_d  = '0;
          blk_d   = '0;
        end
      end
      FETCH:   if (last_issue) state_d = DRAIN;
      DRAIN:   if (frame_done_d) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      mbx_q        <= '0;
      mby_q        <= '0;
      word_q       <= '0;
      blk_q        <= '0;
      inflight_q   <= 1'b0;
      underflow_q  <= 1'b0;
      block_done_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      mbx_q        <= mbx_d;
      mby_q        <= mby_d;
      word_q       <= word_d;
      blk_q        <= blk_d;
      inflight_q   <= inflight_d;
      underflow_q  <= underflow_d;
      block_done_q <= block_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Base address is data: mem_addr is gated by mem_rd, so it needs no reset.
  always_ff @(posedge clk) begin
    base_q <= base_d;
  end

  // Clearing inflight on reset drops the response of a read still in flight.
  cur_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .wdata     (mem_rdata),
    .pop       (pop),
    .count     (fifo_count),
    .head      (fifo_head),
    .not_empty (fifo_nempty)
  );

  assign mem_rd     = issue;
  assign mem_addr   = issue ? issue_addr : '0;
  assign cur_in     = fifo_head;
  assign cur_valid  = fifo_nempty;
  assign block_done = block_done_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != IDLE);
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_cur_fetch.sv
module tb_cur_fetch;

  localparam int FW     = 64;
  localparam int FH     = 64;
  localparam int AW     = 16;
  localparam int DEPTH  = 4;
  localparam int NWORDS = (FW / 4) * FH;  // 1024 words per frame

  logic          clk = 1'b0;
  logic          rst, start, need_cur;
  logic [AW-1:0] frame_base;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;
  logic [31:0]   cur_in;
  logic          cur_valid, block_done, frame_done, busy, underflow;

  always #5 clk = ~clk;

  cur_fetch #(
    .FRAME_W    (FW),
    .FRAME_H    (FH),
    .ADDR_W     (AW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .frame_base (frame_base),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .need_cur   (need_cur),
    .cur_in     (cur_in),
    .cur_valid  (cur_valid),
    .block_done (block_done),
    .frame_done (frame_done),
    .busy       (busy),
    .underflow  (underflow)
  );

  // Frame memory: returns its own address, one cycle after the read.
  always @(posedge clk) mem_rdata <= mem_rd ? {16'h0, mem_addr} : 32'hDEAD_BEEF;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: bound expired, awaited event not seen (t=%0t)", name, $time);
  endtask

  // Word idx of a frame, from raster macroblock order and row-major 4-word rows.
  function automatic logic [31:0] exp_word(input logic [AW-1:0] base, input int idx);
    int blk, w, row, col, mbx, mby;
    logic [AW-1:0] a;
    blk = idx / 64;
    w   = idx % 64;
    row = w / 4;
    col = w % 4;
    mbx = blk % (FW / 16);
    mby = blk / (FW / 16);
    a   = base + AW'((mby * 16 + row) * (FW / 4) + mbx * 4 + col);
    return {16'h0, a};
  endfunction

  // Model state: counts of words issued, arrived and popped in this frame.
  bit            chk_en = 1'b0;
  bit            m_busy = 1'b0, m_uf = 1'b0, m_bd = 1'b0, m_fd = 1'b0, m_pend = 1'b0;
  int            m_iss = 0, m_arr = 0, m_pop = 0;
  logic [AW-1:0] m_base = '0;
  logic [31:0]   got [NWORDS];
  int            pop_cnt = 0, bd_cnt = 0, fd_cnt = 0, rd_cnt = 0;

  bit            c_cv, c_pop, c_rd, c_acc;
  logic [31:0]   c_exp;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        c_cv = (m_arr > m_pop);
        c_rd = m_busy && (m_iss < NWORDS) && ((m_iss - m_pop) < DEPTH);
        chk("busy", busy, m_busy);
        chk("cur_valid", cur_valid, c_cv);
        chk("mem_rd", mem_rd, c_rd);
        chk("block_done", block_done, m_bd);
        chk("frame_done", frame_done, m_fd);
        chk("underflow", underflow, m_uf);
        if (c_cv) begin
          c_exp = exp_word(m_base, m_pop);
          chk("cur_in", cur_in, c_exp);
        end else begin
          chk("cur_in_empty", cur_in, 32'h0);
        end
        if (c_rd && mem_rd) begin
          c_exp = exp_word(m_base, m_iss);
          chk("mem_addr", {16'h0, mem_addr}, c_exp);
        end
        if (mem_rd)     rd_cnt++;
        if (block_done) bd_cnt++;
        if (frame_done) fd_cnt++;

        if (rst) begin
          m_busy = 1'b0; m_uf = 1'b0; m_bd = 1'b0; m_fd = 1'b0; m_pend = 1'b0;
          m_iss = 0; m_arr = 0; m_pop = 0;
        end else begin
          c_pop = need_cur && c_cv;
          c_acc = start && !m_busy;
          if (c_pop) begin
            got[m_pop] = cur_in;
            pop_cnt++;
          end
          m_bd = c_pop && (m_pop % 64 == 63);
          m_fd = c_pop && (m_pop == NWORDS - 1);
          if (c_acc)                 m_uf = 1'b0;
          else if (need_cur && !c_cv) m_uf = 1'b1;
          if (m_pend) m_arr++;
          m_pend = c_rd;
          if (c_rd)  m_iss++;
          if (c_pop) m_pop++;
          if (c_acc) begin
            m_busy = 1'b1; m_base = frame_base;
            m_iss = 0; m_arr = 0; m_pop = 0; m_pend = 1'b0;
          end else if (m_fd) begin
            m_busy = 1'b0;
          end
        end
      end
    end
  end

  task automatic do_start(input logic [AW-1:0] base);
    pop_cnt = 0; bd_cnt = 0; fd_cnt = 0; rd_cnt = 0;
    frame_base = base;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int i = 0;
    while (!cur_valid && i < budget) begin @(posedge clk); #1; i++; end
    if (!cur_valid) timeout_fail("wait_valid");
  endtask

  task automatic wait_pops(input int n, input int budget);
    int i = 0;
    while (pop_cnt < n && i < budget) begin @(posedge clk); #1; i++; end
    if (pop_cnt < n) timeout_fail("wait_pops");
  endtask

  task automatic wait_frame_done(input int budget);
    int i = 0;
    while (!frame_done && i < budget) begin @(posedge clk); #1; i++; end
    if (!frame_done) timeout_fail("wait_frame_done");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; need_cur = 1'b0; frame_base = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_cur_in", cur_in, 0);
    chk("rst_cur_valid", cur_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_block_done", block_done, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_underflow", underflow, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Full frame at 0x0100 with a backpressure window mid-block.
    do_start(16'h0100);
    wait_valid(10);
    need_cur = 1'b1;
    wait_pops(100, 500);
    need_cur = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("bp_mem_rd_idle", mem_rd, 0);
    chk("bp_cur_valid", cur_valid, 1);
    chk("bp_buffered", rd_cnt - pop_cnt, DEPTH);
    need_cur = 1'b1;
    wait_frame_done(3000);
    need_cur = 1'b0;
    @(posedge clk); #1;
    chk("f1_pops", pop_cnt, NWORDS);
    chk("f1_word1", got[0], 32'h0100);
    chk("f1_word2", got[1], 32'h0101);
    chk("f1_word5", got[4], 32'h0110);
    chk("f1_word64", got[63], 32'h01F3);
    chk("f1_word65", got[64], 32'h0104);
    chk("f1_word257", got[256], 32'h0200);
    chk("f1_block_done_cnt", bd_cnt, 16);
    chk("f1_frame_done_cnt", fd_cnt, 1);
    chk("f1_busy_fell", busy, 0);
    chk("f1_no_underflow", underflow, 0);

    // Early need_cur -> sticky underflow; start while busy is ignored.
    do_start(16'h0000);
    need_cur = 1'b1;
    @(posedge clk); #1;
    chk("uf_set", underflow, 1);
    chk("uf_no_pop", pop_cnt, 0);
    wait_pops(300, 1000);
    frame_base = 16'h3000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_frame_done(3000);
    need_cur = 1'b0;
    @(posedge clk); #1;
    chk("f2_underflow_sticky", underflow, 1);
    chk("f2_pops", pop_cnt, NWORDS);
    chk("f2_first", got[0], 32'h0000);
    chk("f2_last", got[NWORDS-1], 32'h03FF);
    chk("f2_frame_done_cnt", fd_cnt, 1);

    // New start clears underflow; reset mid-frame aborts cleanly.
    do_start(16'hFFF0);
    chk("f3_uf_cleared", underflow, 0);
    wait_valid(10);
    need_cur = 1'b1;
    wait_pops(50, 300);
    rst = 1'b1;
    need_cur = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_cur_valid", cur_valid, 0);
    chk("abort_mem_rd", mem_rd, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_dropped_read", cur_valid, 0);

    // Restart after abort, with address wrap past 0xFFFF.
    do_start(16'hFFF0);
    wait_valid(10);
    need_cur = 1'b1;
    wait_frame_done(3000);
    need_cur = 1'b0;
    @(posedge clk); #1;
    chk("f4_first", got[0], 32'hFFF0);
    chk("f4_wrap_row1", got[4], 32'h0000);
    chk("f4_wrap_row1b", got[5], 32'h0001);
    chk("f4_pops", pop_cnt, NWORDS);
    chk("f4_frame_done_cnt", fd_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
